// File: rtl/apb4_mem.sv
// APB4 slave scratch memory with byte strobes, programmable wait states and PSLVERR
// on out-of-range or misaligned accesses.
module apb4_mem #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = (NumLanes > 1) ? $clog2(NumLanes) : 0;
  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e                r_state, w_state_d;
  logic [3:0]            r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_lane_mask;
  logic [IdxW-1:0]       w_idx;
  logic                  w_err;
  logic                  w_enter;
  logic                  w_commit;

  assign w_word      = PADDR >> LaneBits;
  assign w_lane_mask = ~({ADDR_WIDTH{1'b1}} << LaneBits);
  assign w_idx       = w_word[IdxW-1:0];
  assign w_err       = (w_word >= ADDR_WIDTH'(MEM_DEPTH)) || (|(PADDR & w_lane_mask));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        // A select with PENABLE already high is a protocol violation and is ignored.
        if (PSEL && !PENABLE) begin
          if (WAIT_STATES == 0) begin
            w_state_d = StAccess;
          end else begin
            w_state_d = StWait;
            w_cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!PSEL) begin
          w_state_d = StIdle;
          w_cnt_d   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_d = StAccess;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StAccess: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  assign w_enter  = (w_state_d == StAccess);
  // The error flag registered on entry to ACCESS gates the commit at its end.
  assign w_commit = PRESETn && (r_state == StAccess) && PSEL && PENABLE && r_pready &&
                    PWRITE && !r_pslverr;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_pready  <= w_enter;
      r_pslverr <= w_enter && w_err;
      if (w_enter && !PWRITE) begin
        r_prdata <= w_err ? '0 : r_mem[w_idx];
      end
    end
  end

  // Storage is deliberately not reset so contents survive PRESETn.
  always_ff @(posedge PCLK) begin
    if (w_commit) begin
      for (int unsigned i = 0; i < NumLanes; i++) begin
        if (PSTRB[i]) begin
          r_mem[w_idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
        end
      end
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb4_mem.sv
// Scoreboard bench for apb4_mem: three instances with 0, 3 and 2 wait states share one bus.
module tb_apb4_mem;

  logic        clk;
  logic        rst_n;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel    [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          inst;
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_mem #(.WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );
  apb4_mem #(.WAIT_STATES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );
  apb4_mem #(.WAIT_STATES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per PREADY pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!pready[i] && pslverr[i]) begin
          checks++;
          failures++;
          $display("FAIL pslverr_without_pready: inst %0d got 1 expected 0", i);
        end
        if (pready[i]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pready: inst %0d cycle %0d got 1 expected 0", i, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.inst != i) begin
              failures++;
              $display("FAIL pready_inst: got %0d expected %0d", i, e.inst);
            end
            check("pready_cycle", cyc, e.cyc);
            check("pslverr", {31'd0, pslverr[i]}, {31'd0, e.err});
            if (e.rd) check("prdata", prdata[i], e.data);
          end
        end
      end
    end
  end

  task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input bit err, input logic [31:0] edata);
    int   ws;
    int   n;
    exp_t e;
    ws = (inst == 0) ? 0 : (inst == 1) ? 3 : 2;
    psel[inst] = 1'b1;
    penable    = 1'b0;
    pwrite     = wr;
    paddr      = addr;
    pwdata     = data;
    pstrb      = strb;
    e = '{inst: inst, rd: !wr, err: err, data: edata, cyc: cyc + 1 + ws};
    sb.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready[inst] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pready[inst]) begin
      checks++;
      failures++;
      $display("FAIL pready_timeout: inst %0d got 0 expected 1", inst);
    end
    @(posedge clk); #1;
    psel[inst] = 1'b0;
    penable    = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_prdata", prdata[i], 32'h0);
      check("reset_pready", {31'd0, pready[i]}, 32'h0);
      check("reset_pslverr", {31'd0, pslverr[i]}, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: full writes, strobes, boundary word, back-to-back.
    xfer(0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0);
    xfer(0, 0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEEF);
    xfer(0, 1, 32'h10,   32'h11223344, 4'h5, 0, 32'h0);
    xfer(0, 0, 32'h10,   32'h0,        4'h0, 0, 32'hDE22BE44);
    xfer(0, 1, 32'h10,   32'hFFFFFFFF, 4'h0, 0, 32'h0);
    xfer(0, 0, 32'h10,   32'h0,        4'h0, 0, 32'hDE22BE44);
    xfer(0, 1, 32'hFFC,  32'h0BADF00D, 4'hF, 0, 32'h0);
    xfer(0, 0, 32'hFFC,  32'h0,        4'h0, 0, 32'h0BADF00D);

    // Errors: first out-of-range word, then a misaligned write.
    xfer(0, 0, 32'h1000, 32'h0,        4'h0, 1, 32'h0);
    xfer(0, 1, 32'h12,   32'hAAAAAAAA, 4'hF, 1, 32'h0);
    xfer(0, 0, 32'h10,   32'h0,        4'h0, 0, 32'hDE22BE44);

    // Reset with the bus mid-write: outputs clear and memory keeps its contents.
    rst_n   = 1'b0;
    psel[0] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'h55555555;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_prdata", prdata[0], 32'h0);
    check("rst_mid_pready", {31'd0, pready[0]}, 32'h0);
    check("rst_mid_pslverr", {31'd0, pslverr[0]}, 32'h0);
    psel[0] = 1'b0;
    penable = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44);

    // Three wait states.
    xfer(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    xfer(1, 0, 32'h10, 32'h0,        4'h0, 0, 32'hDEADBEEF);

    // Two wait states, then a write aborted during WAIT.
    xfer(2, 1, 32'h20, 32'h12345678, 4'hF, 0, 32'h0);
    xfer(2, 0, 32'h20, 32'h0,        4'h0, 0, 32'h12345678);
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'hCAFEF00D;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0;
    penable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_pready", {31'd0, pready[2]}, 32'h0);
    xfer(2, 0, 32'h20, 32'h0, 4'h0, 0, 32'h12345678);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb4_mem.md
# apb4_mem

Parametrised APB4 slave memory, next generation of the team's APB single-port memory slave. Adds configurable data, address and depth widths, byte-lane write strobes (PSTRB), programmable wait states and PSLVERR signalling for out-of-range and misaligned accesses. Sits on the peripheral bus behind the APB bridge as a register-file / scratch RAM target.

## Interface
- ADDR_WIDTH, 32: PADDR width, byte address.
- DATA_WIDTH, 32: PWDATA/PRDATA width; must be 8, 16, 32 or 64.
- MEM_DEPTH, 1024: number of DATA_WIDTH words; must be ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase; 0..15.
- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables; ignored on reads.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer completion, registered.
- PSLVERR  out  1  transfer error, registered; valid only while PREADY=1.

## Operation
- Word index = PADDR >> log2(DATA_WIDTH/8); lane offset = PADDR low log2(DATA_WIDTH/8) bits.
- Error (PSLVERR=1) if index ≥ MEM_DEPTH or lane offset ≠ 0.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: PREADY=0. On PSEL=1 & PENABLE=0 (setup cycle): if WAIT_STATES=0 → ACCESS, else → WAIT with counter loaded WAIT_STATES-1. PSEL=1 & PENABLE=1 in IDLE (protocol violation) ignored, stays IDLE.
  - WAIT: PREADY=0. If PSEL=0 → IDLE (abort, no memory effect). Else counter=0 → ACCESS, otherwise decrement.
  - ACCESS: PREADY=1 for exactly one cycle; always → IDLE next edge.
- On transition into ACCESS (same edge PREADY rises): PSLVERR computed; for reads, PRDATA ← MEM[index], or 0 on error.
- Write commit on the edge ending ACCESS (PSEL=PENABLE=PREADY=1 sampled): each byte lane i with PSTRB[i]=1 ← PWDATA lane i. Error or PSTRB=0 → memory unchanged (PSTRB=0 is not an error).
- Abort in ACCESS (PSEL=0 sampled at its end): write not committed.
- PRDATA holds last value except at read-capture edges; unchanged by writes and errored writes.
- Memory array not reset; contents undefined after power-up, preserved across PRESETn.

## Timing
- Reset (PRESETn=0 at rising edge): state IDLE, PRDATA=0, PREADY=0, PSLVERR=0, counter=0. Reset mid-transfer aborts; pending write not committed.
- Transfer = 1 setup + WAIT_STATES + 1 cycles; PREADY high in cycle 2+WAIT_STATES counted from setup cycle 1.
- PSLVERR and PRDATA valid in the PREADY=1 cycle; PSLVERR=0 in all other cycles.
- Back-to-back: next setup cycle may immediately follow ACCESS; IDLE samples it, no idle bubble added beyond protocol.
- Read after write to same address in the next transfer returns new data.
- No combinational path input→output.

## Test plan
- Reset: drive PRESETn=0 two cycles with bus active → PRDATA=0, PREADY=0, PSLVERR=0; no write committed.
- WAIT_STATES=0, DATA_WIDTH=32: write 0xDEADBEEF to PADDR 0x10, PSTRB=0xF, then read 0x10 → PREADY high in cycle 2 of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: after above, write 0x11223344 with PSTRB=0x5 to 0x10, read → 0xDE22BE44; PSTRB=0x0 write → unchanged.
- WAIT_STATES=3: read 0x10 → PREADY low for 3 access cycles, high in cycle 5 only; PRDATA valid there.
- Errors, MEM_DEPTH=1024: read 0x1000 → PSLVERR=1, PRDATA=0; write 0x12 (misaligned) → PSLVERR=1, word 0x10 unchanged.
- Abort: WAIT_STATES=2, write 0xCAFEF00D to 0x20, drop PSEL during WAIT → returns IDLE, PREADY never high, read 0x20 returns prior value.
